// File: rtl/scope_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scope_pkg
//  Description : Shared constants and types for the scope ADC capture path:
//                decimator mode codes, default geometry and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package scope_pkg;

    // Decimator mode codes, as seen on iMode
    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_DECIM = 2'd1;
    localparam logic [1:0] MODE_AVG   = 2'd2;
    localparam logic [1:0] MODE_PEAK  = 2'd3;

    // Default geometry: 8-bit samples, 8-bit divider, 10 MHz ADC from 100 MHz
    localparam int DATA_WIDTH_DEFAULT   = 8;
    localparam int DIV_WIDTH_DEFAULT    = 8;
    localparam int HALF_PERIOD_DEFAULT  = 5;
    localparam int MAX_DEC_LOG2_DEFAULT = 7;

    // Capture state machine
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/adc_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : adc_clk_gen
//  Description : ADC clock divider. Toggles the ADC clock every i_half system
//                clocks while running and flags the edge on which the ADC
//                clock falls so the parent can capture data on that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_clk_gen #(
    parameter int pDivWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_run,
    input  logic [pDivWidth-1:0] i_half,
    output logic                 o_adc_clk,
    output logic                 o_fall
);

    logic [pDivWidth-1:0] r_cnt_q;
    logic [pDivWidth-1:0] w_cnt_d;
    logic                 r_clk_q;
    logic                 w_clk_d;
    logic                 w_wrap;

    // i_half is already forced to at least 1 by the parent's shadow register
    assign w_wrap = (r_cnt_q == (i_half - pDivWidth'(1)));

    // Divider next state: hold at zero/low when not running, toggle on wrap
    always_comb begin
        w_cnt_d = r_cnt_q;
        w_clk_d = r_clk_q;
        if (!i_run) begin
            w_cnt_d = '0;
            w_clk_d = 1'b0;
        end else if (w_wrap) begin
            w_cnt_d = '0;
            w_clk_d = ~r_clk_q;
        end else begin
            w_cnt_d = r_cnt_q + pDivWidth'(1);
        end
    end

    // Divider registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
            r_clk_q <= 1'b0;
        end else begin
            r_cnt_q <= w_cnt_d;
            r_clk_q <= w_clk_d;
        end
    end

    assign o_adc_clk = r_clk_q;
    // High during the cycle whose closing edge drives the ADC clock 1 -> 0
    assign o_fall    = i_run && w_wrap && r_clk_q;

endmodule
`default_nettype wire

// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture
//  Description : ADC sampler with runtime clock divider, falling-edge capture,
//                pass/decimate/average/peak decimator and a single-entry
//                valid/ready output stage with sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_capture
    import scope_pkg::*;
#(
    parameter int pDataWidth  = DATA_WIDTH_DEFAULT,
    parameter int pDivWidth   = DIV_WIDTH_DEFAULT,
    parameter int pMaxDecLog2 = MAX_DEC_LOG2_DEFAULT,
    parameter int pAccWidth   = pDataWidth + pMaxDecLog2
) (
    input  logic                               iCLK,
    input  logic                               iRST,
    input  logic                               iEnable,
    input  logic [pDivWidth-1:0]               iHalfPeriod,
    input  logic [$clog2(pMaxDecLog2+1)-1:0]   iDecimLog2,
    input  logic [1:0]                         iMode,
    input  logic [pDataWidth-1:0]              iADC_Data,
    input  logic                               iData_Ready,
    input  logic                               iClearOvf,
    output logic                               oADC_CLK,
    output logic                               oADC_nOE,
    output logic [pDataWidth-1:0]              oADC_Data,
    output logic                               oData_Valid,
    output logic                               oOverflow
);

    localparam int                 C_DEC_W   = $clog2(pMaxDecLog2 + 1);
    localparam logic [C_DEC_W-1:0] C_MAX_DEC = C_DEC_W'(pMaxDecLog2);

    // FSM and config shadows
    state_e                  r_state_q, w_state_d;
    logic                    r_noe_q,   w_noe_d;
    logic [pDivWidth-1:0]    r_half_q,  w_half_d;
    logic [C_DEC_W-1:0]      r_dec_q,   w_dec_d;
    logic [1:0]              r_mode_q,  w_mode_d;
    // Capture
    logic                    w_run;
    logic                    w_fall;
    logic [pDataWidth-1:0]   r_sample_q, w_sample_d;
    logic                    r_strobe_q, w_strobe_d;
    // Decimator
    logic [pMaxDecLog2-1:0]  r_win_q,  w_win_d;
    logic [pMaxDecLog2-1:0]  w_win_max;
    logic [pAccWidth-1:0]    r_acc_q,  w_acc_d;
    logic [pAccWidth-1:0]    w_sum;
    logic [pDataWidth-1:0]   r_keep_q, w_keep_d;
    logic [pDataWidth-1:0]   w_peak;
    logic [pDataWidth-1:0]   w_result;
    logic                    w_res_valid;
    logic                    w_first;
    logic                    w_last;
    // Output stage
    logic [pDataWidth-1:0]   r_data_q,  w_data_d;
    logic                    r_valid_q, w_valid_d;
    logic                    r_ovf_q,   w_ovf_d;

    // The divider only counts in RUN while enable holds; the exit edge forces it low
    assign w_run = (r_state_q == ST_RUN) && iEnable;

    adc_clk_gen #(
        .pDivWidth (pDivWidth)
    ) u_clk_gen (
        .clk       (iCLK),
        .rst       (iRST),
        .i_run     (w_run),
        .i_half    (r_half_q),
        .o_adc_clk (oADC_CLK),
        .o_fall    (w_fall)
    );

    // State transitions and config shadowing (shadows track inputs only in IDLE)
    always_comb begin
        w_state_d = r_state_q;
        w_noe_d   = r_noe_q;
        w_half_d  = r_half_q;
        w_dec_d   = r_dec_q;
        w_mode_d  = r_mode_q;
        if (r_state_q == ST_IDLE) begin
            w_half_d = (iHalfPeriod == '0) ? pDivWidth'(1) : iHalfPeriod;
            w_dec_d  = (iDecimLog2 > C_MAX_DEC) ? C_MAX_DEC : iDecimLog2;
            w_mode_d = iMode;
            if (iEnable) begin
                w_state_d = ST_RUN;
                w_noe_d   = 1'b0;
            end
        end else if (!iEnable) begin
            w_state_d = ST_IDLE;
            w_noe_d   = 1'b1;
        end
    end

    // Sample register loads on the ADC clock falling edge
    always_comb begin
        w_sample_d = w_fall ? iADC_Data : r_sample_q;
        w_strobe_d = w_fall;
    end

    // Window bookkeeping shared by all decimator modes
    assign w_win_max = ~({pMaxDecLog2{1'b1}} << r_dec_q);
    assign w_first   = (r_win_q == '0);
    assign w_last    = (r_mode_q == MODE_PASS) || (r_win_q == w_win_max);
    assign w_sum     = r_acc_q + pAccWidth'(r_sample_q);
    assign w_peak    = (w_first || (r_sample_q > r_keep_q)) ? r_sample_q : r_keep_q;

    // Decimator: one step per sample strobe; IDLE discards any partial window
    always_comb begin
        w_win_d     = r_win_q;
        w_acc_d     = r_acc_q;
        w_keep_d    = r_keep_q;
        w_result    = '0;
        w_res_valid = 1'b0;
        if (r_state_q == ST_IDLE) begin
            w_win_d  = '0;
            w_acc_d  = '0;
            w_keep_d = '0;
        end else if (r_strobe_q) begin
            w_res_valid = w_last;
            w_win_d     = w_last ? '0 : (r_win_q + pMaxDecLog2'(1));
            case (r_mode_q)
                MODE_PASS: begin
                    w_result = r_sample_q;
                end
                MODE_DECIM: begin
                    w_result = w_first ? r_sample_q : r_keep_q;
                    w_keep_d = w_result;
                end
                MODE_AVG: begin
                    w_result = pDataWidth'(w_sum >> r_dec_q);
                    w_acc_d  = w_last ? '0 : w_sum;
                end
                default: begin
                    w_result = w_peak;
                    w_keep_d = w_peak;
                end
            endcase
        end
    end

    // Output stage: single entry, drop-on-full with sticky overflow (set beats clear)
    always_comb begin
        w_data_d  = r_data_q;
        w_valid_d = r_valid_q;
        w_ovf_d   = r_ovf_q;
        if (r_valid_q && iData_Ready) begin
            w_valid_d = 1'b0;
        end
        if (iClearOvf) begin
            w_ovf_d = 1'b0;
        end
        if (w_res_valid) begin
            if (r_valid_q && !iData_Ready) begin
                w_ovf_d = 1'b1;
            end else begin
                w_data_d  = w_result;
                w_valid_d = 1'b1;
            end
        end
    end

    // All state registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state_q  <= ST_IDLE;
            r_noe_q    <= 1'b1;
            r_half_q   <= pDivWidth'(HALF_PERIOD_DEFAULT);
            r_dec_q    <= '0;
            r_mode_q   <= MODE_PASS;
            r_sample_q <= '0;
            r_strobe_q <= 1'b0;
            r_win_q    <= '0;
            r_acc_q    <= '0;
            r_keep_q   <= '0;
            r_data_q   <= '0;
            r_valid_q  <= 1'b0;
            r_ovf_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_noe_q    <= w_noe_d;
            r_half_q   <= w_half_d;
            r_dec_q    <= w_dec_d;
            r_mode_q   <= w_mode_d;
            r_sample_q <= w_sample_d;
            r_strobe_q <= w_strobe_d;
            r_win_q    <= w_win_d;
            r_acc_q    <= w_acc_d;
            r_keep_q   <= w_keep_d;
            r_data_q   <= w_data_d;
            r_valid_q  <= w_valid_d;
            r_ovf_q    <= w_ovf_d;
        end
    end

    assign oADC_nOE    = r_noe_q;
    assign oADC_Data   = r_data_q;
    assign oData_Valid = r_valid_q;
    assign oOverflow   = r_ovf_q;

endmodule
`default_nettype wire

// File: doc/adc_capture.md
Name: adc_capture

Overview:
Parametrised successor to the fixed 10 MHz ADC sampler. It generates the ADC clock from iCLK with a runtime divider and captures ADC data on the ADC clock falling edge. Captured samples pass through a decimator with selectable mode (pass, decimate, average, peak), then leave through a single-entry valid/ready output stage with sticky overflow detection. The block sits between the ADC pins and the capture buffer/trigger logic of the scope.

Parameters:
pDataWidth, 8, ADC sample width in bits
pDivWidth, 8, width of the half-period divider value
pMaxDecLog2, 7, maximum decimation exponent; decimation factor is 2^n, n in 0..pMaxDecLog2
pAccWidth, pDataWidth+pMaxDecLog2, accumulator width (derived; do not override)

Ports:
iCLK  in  1  system clock (100 MHz nominal)
iRST  in  1  reset; synchronous, active-high
iEnable  in  1  1 = RUN (ADC clocked and captured), 0 = IDLE
iHalfPeriod  in  pDivWidth  iCLK cycles per ADC clock half-period; 0 is treated as 1
iDecimLog2  in  $clog2(pMaxDecLog2+1)  decimation exponent n; values above pMaxDecLog2 clamp to pMaxDecLog2
iMode  in  2  0 PASS, 1 DECIM (first sample of window), 2 AVG (truncated mean), 3 PEAK (unsigned max)
iADC_Data  in  pDataWidth  ADC parallel data
iData_Ready  in  1  downstream accepts oADC_Data when oData_Valid=1
iClearOvf  in  1  clears oOverflow
oADC_CLK  out  1  ADC clock
oADC_nOE  out  1  ADC output enable, active low
oADC_Data  out  pDataWidth  result sample
oData_Valid  out  1  result valid
oOverflow  out  1  sticky: a result was dropped

Behaviour:
- Reset (iRST=1 at a rising edge of iCLK): oADC_CLK=0, oADC_nOE=1, oADC_Data=0, oData_Valid=0, oOverflow=0. Divider, window counter and accumulator are 0. State is IDLE. Reset mid-window discards all partial data.
- Config shadows: iHalfPeriod, iDecimLog2 and iMode load into shadow registers on every cycle in IDLE. They are frozen in RUN, so changes made while running take effect only after the next IDLE pass.
- State machine, two states:
  - IDLE to RUN when iEnable=1. On entry: divider=0, oADC_CLK=0, oADC_nOE=0, window counter=0.
  - RUN to IDLE when iEnable=0, taking effect on the next cycle. On entry: oADC_CLK=0, oADC_nOE=1, partial window discarded. A pending output result is retained until accepted.
- Divider (H = shadowed half-period, min 1): in RUN, the counter increments each cycle. When it reaches H-1 it wraps to 0 and oADC_CLK toggles. The first rise of oADC_CLK occurs H cycles after RUN entry and the first fall 2H cycles after entry. f_ADC = f_iCLK/(2H); H=5 gives 10 MHz.
- Capture: in the same cycle oADC_CLK is driven 1 to 0, iADC_Data is registered as the sample and a sample strobe fires.
- Decimator, operating on each sample strobe (window length W = 2^n, window counter k = 0..W-1):
  - PASS: every sample produces a result; n is ignored.
  - DECIM: the sample at k=0 is the result, emitted when k=W-1.
  - AVG: the accumulator sums W samples unsigned at pAccWidth. At k=W-1 the result is (sum incl. current) >> n, truncated. The accumulator restarts with the next sample.
  - PEAK: result is the unsigned max over the window, emitted at k=W-1.
  - With n=0, all modes equal PASS.
- Result latency: the result is registered into oADC_Data/oData_Valid one cycle after the capture cycle of its last sample.
- Output stage:
  - oData_Valid stays 1 until a cycle with iData_Ready=1.
  - New result while valid=1 and ready=0: the new result is dropped, oADC_Data is unchanged, and oOverflow sets.
  - New result in the same cycle as a handshake (valid=1, ready=1): the new result loads and valid stays 1.
  - iClearOvf and a new overflow in the same cycle: overflow wins (stays 1).
- No combinational path from any input to any output.

Decomposition:
- Shared package scope_pkg: mode constants MODE_PASS=0, MODE_DECIM=1, MODE_AVG=2, MODE_PEAK=3; default half-period 5; pMaxDecLog2 default.
- One sub-module, adc_clk_gen: divider, oADC_CLK generation and fall-strobe. Inputs: clock, reset, run, half-period. Outputs: ADC clock, strobe. The decimator and output stage stay in adc_capture.

Test Plan:
- Reset then iEnable=1, H=5, PASS, ADC data ramp 0,1,2... -> oADC_CLK period 10 cycles; first rise 5 cycles after RUN entry, first fall at 10 cycles; oADC_nOE=0; each result valid one cycle after its fall, one result per 10 cycles, values increasing by 1 per result.
- H=0 vs H=1 -> identical 2-cycle ADC clock period; H=255 -> 510-cycle period.
- AVG, n=2, samples 10,11,12,14 -> single result 11 (47>>2); PEAK same samples -> 14; DECIM -> 10; all emitted one cycle after the 4th fall.
- iData_Ready=0 held across two PASS results -> first result retained on oADC_Data, oOverflow=1; iClearOvf pulse -> 0; ready=1 and new result in the same cycle -> new value loads, valid stays 1.
- iEnable dropped mid AVG window (2 of 4 samples), then re-enabled -> oADC_CLK=0 and oADC_nOE=1 while IDLE; first post-restart result averages only post-restart samples; iMode change made during RUN is ignored until IDLE.
- iRST asserted mid-RUN with valid=1 -> next cycle all outputs at reset values; block stays IDLE until iEnable seen after iRST deasserts.
